// File: rtl/spi_lcd_ctrl.sv
// spi_lcd_ctrl: sequences one SPI mode-0, MSB-first byte shift register on the
// ILI9341 LCD link. It takes command/data bytes from a valid/ready stream,
// drives the shift register's load/shift strobes, and generates SCK, CS_n and D/C.
// CS_n stays low across back-to-back bytes, so they form a single burst.
//
// Ports
//   clk, rst        system clock, asynchronous active-high reset
//   tx_valid/ready  byte stream handshake; tx_data/tx_dc travel with it
//   sr_load/sr_data parallel load into the external shift register (= handshake)
//   sr_shift_en     one-clk shift strobe, coincident with each SCK falling edge
//   spi_sck/cs_n/dc SPI link pins (SCK idles low, CS_n active low)
//   busy            controller is not IDLE
//   byte_done       one-clk pulse after the last bit of a byte
module spi_lcd_ctrl #(
    parameter int unsigned DW       = 8,
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_IDLE  = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tx_valid,
    output logic          tx_ready,
    input  logic [DW-1:0] tx_data,
    input  logic          tx_dc,
    output logic          sr_load,
    output logic [DW-1:0] sr_data,
    output logic          sr_shift_en,
    output logic          spi_sck,
    output logic          spi_cs_n,
    output logic          spi_dc,
    output logic          busy,
    output logic          byte_done
);

    localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W    = $clog2(DW + 1);
    localparam int unsigned WAIT_MAX = (CS_SETUP > CS_IDLE) ? CS_SETUP : CS_IDLE;
    localparam int unsigned WAIT_W   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
    // Half-period count one before the last; unused when CLK_DIV == 1.
    localparam logic [DIV_W-1:0]  DIV_PRE    = DIV_W'((CLK_DIV > 1) ? (CLK_DIV - 2) : 0);
    localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(DW - 1);
    localparam logic [WAIT_W-1:0] SETUP_LAST = WAIT_W'(CS_SETUP - 1);
    localparam logic [WAIT_W-1:0] IDLE_LAST  = WAIT_W'(CS_IDLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        NEXT,
        HOLD
    } state_t;

    state_t             state;
    logic [DIV_W-1:0]   div_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [WAIT_W-1:0]  wait_cnt;

    // Stream handshake and shift-register load path
    assign tx_ready = !rst && (state == IDLE || state == NEXT);
    assign sr_load  = tx_valid && tx_ready;
    assign sr_data  = tx_data;
    assign busy     = (state != IDLE);

    // Sequencer: CS framing, SCK generation and shift strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            spi_cs_n    <= 1'b1;
            spi_sck     <= 1'b0;
            spi_dc      <= 1'b0;
            sr_shift_en <= 1'b0;
            byte_done   <= 1'b0;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            wait_cnt    <= '0;
        end else begin
            sr_shift_en <= 1'b0;
            byte_done   <= 1'b0;
            if (sr_load) begin
                spi_dc <= tx_dc;
            end
            case (state)
                IDLE: begin
                    if (sr_load) begin
                        state    <= SETUP;
                        spi_cs_n <= 1'b0;
                        wait_cnt <= '0;
                    end
                end
                SETUP: begin
                    if (wait_cnt == SETUP_LAST) begin
                        state   <= XFER;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                XFER: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (!spi_sck) begin
                            spi_sck     <= 1'b1;
                            // With a one-cycle half period the high cycle is also the last one.
                            sr_shift_en <= (CLK_DIV == 1);
                        end else begin
                            spi_sck <= 1'b0;
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            if (bit_cnt == BIT_LAST) begin
                                byte_done <= 1'b1;
                                state     <= NEXT;
                            end
                        end
                    end else begin
                        div_cnt     <= div_cnt + DIV_W'(1);
                        // Strobe lands on the last high cycle so the shift coincides with SCK fall.
                        sr_shift_en <= spi_sck && (div_cnt == DIV_PRE);
                    end
                end
                NEXT: begin
                    if (sr_load) begin
                        state   <= XFER;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                    end else begin
                        state    <= HOLD;
                        spi_cs_n <= 1'b1;
                        wait_cnt <= '0;
                    end
                end
                HOLD: begin
                    if (wait_cnt == IDLE_LAST) begin
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_lcd_ctrl.sv
// Testbench for spi_lcd_ctrl: reset behaviour, single-byte vectors, bursts,
// HOLD gap handling, strobe accounting, a fast-SCK instance and random traffic
// checked against a transaction-level model of the link.
module tb_spi_lcd_ctrl;

    localparam int unsigned DW       = 8;
    localparam int unsigned CLK_DIV  = 2;
    localparam int unsigned CS_SETUP = 2;
    localparam int unsigned CS_IDLE  = 2;
    localparam int unsigned BYTE_CYC = 2 * CLK_DIV * DW + 1;  // XFER time plus the NEXT cycle

    logic          clk;
    logic          rst;
    logic          tx_valid, tx_ready, tx_dc;
    logic [DW-1:0] tx_data, sr_data;
    logic          sr_load, sr_shift_en, spi_sck, spi_cs_n, spi_dc, busy, byte_done;

    logic          b_valid, b_ready, b_dc;
    logic [DW-1:0] b_data, b_sr_data;
    logic          b_sr_load, b_shift_en, b_sck, b_cs_n, b_spi_dc, b_busy, b_byte_done;

    spi_lcd_ctrl #(.DW(DW), .CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_IDLE(CS_IDLE)) dut (
        .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .tx_dc(tx_dc), .sr_load(sr_load), .sr_data(sr_data), .sr_shift_en(sr_shift_en),
        .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_dc(spi_dc), .busy(busy),
        .byte_done(byte_done)
    );

    spi_lcd_ctrl #(.DW(DW), .CLK_DIV(1), .CS_SETUP(CS_SETUP), .CS_IDLE(CS_IDLE)) dut_fast (
        .clk(clk), .rst(rst), .tx_valid(b_valid), .tx_ready(b_ready), .tx_data(b_data),
        .tx_dc(b_dc), .sr_load(b_sr_load), .sr_data(b_sr_data), .sr_shift_en(b_shift_en),
        .spi_sck(b_sck), .spi_cs_n(b_cs_n), .spi_dc(b_spi_dc), .busy(b_busy),
        .byte_done(b_byte_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // ---------------- link monitor (external shift register + framing) ----------------
    logic [DW-1:0] sreg, cur;
    logic          cur_dc, prev_sck;
    logic [8:0]    obs_q[$];
    int bit_n, high_run, gap, gap_at_start;
    int win_len, win_rises, win_bytes, last_len, last_rises, win_count;
    int loads, shifts, dones;
    int v_coinc, v_busy, v_high, v_win, v_gap;

    initial begin
        sreg = '0; cur = '0; cur_dc = 0; prev_sck = 0; bit_n = 0; high_run = 0; gap = 100;
        gap_at_start = 0; win_len = 0; win_rises = 0; win_bytes = 0; last_len = 0;
        last_rises = 0; win_count = 0; loads = 0; shifts = 0; dones = 0;
        v_coinc = 0; v_busy = 0; v_high = 0; v_win = 0; v_gap = 0;
    end

    logic in_win = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            bit_n = 0; high_run = 0; prev_sck = 0; gap = 100; in_win = 0;
        end else begin
            if (spi_sck && !prev_sck) begin
                if (bit_n == 0) cur_dc = spi_dc;
                cur = {cur[DW-2:0], sreg[DW-1]};
                bit_n++;
                win_rises++;
                if (bit_n == DW) begin
                    obs_q.push_back({cur_dc, cur});
                    bit_n = 0;
                    win_bytes++;
                end
            end
            if (spi_sck) high_run++;
            else if (prev_sck) begin
                if (high_run != CLK_DIV) v_high++;
                high_run = 0;
            end
            if (!spi_cs_n) begin
                if (!in_win) begin
                    in_win = 1; win_len = 0; win_rises = 0; win_bytes = 0;
                    gap_at_start = gap;
                    if (gap < CS_IDLE) v_gap++;
                end
                win_len++;
            end else if (in_win) begin
                in_win = 0; last_len = win_len; last_rises = win_rises; win_count++;
                if (win_len != CS_SETUP + win_bytes * BYTE_CYC) v_win++;
                if (win_rises != DW * win_bytes) v_win++;
                gap = 0;
            end
            if (spi_cs_n) gap++;
            if (busy != (!spi_cs_n || gap <= CS_IDLE)) v_busy++;
            if (sr_load) loads++;
            if (sr_shift_en) shifts++;
            if (byte_done) dones++;
            if (sr_load && sr_shift_en) v_coinc++;
            if (sr_load) sreg = sr_data;
            else if (sr_shift_en) sreg = sreg << 1;
            prev_sck = spi_sck;
        end
    end

    // ---------------- fast instance monitor ----------------
    int b_t = 0, b_lat = 0, b_hi = 0, b_rises = 0;
    logic b_arm = 0, b_prev = 0;

    always @(negedge clk) begin
        if (rst) begin
            b_arm = 0; b_prev = 0;
        end else begin
            if (b_sr_load) begin
                b_t = 0; b_arm = 1; b_hi = 0; b_rises = 0;
            end else if (b_arm) begin
                b_t++;
                if (b_sck) b_hi++;
                if (b_sck && !b_prev) b_rises++;
                if (b_byte_done) begin b_lat = b_t; b_arm = 0; end
            end
            b_prev = b_sck;
        end
    end

    // ---------------- driver helpers ----------------
    task automatic send(input logic [DW-1:0] d, input logic c, input bit drop);
        bit ok = 0;
        int n = 0;
        tx_valid = 1'b1; tx_data = d; tx_dc = c;
        while (!ok && n < 400) begin
            @(negedge clk);
            if (tx_ready) ok = 1;
            n++;
        end
        @(posedge clk); #1;
        if (!ok) begin
            total++;
            $display("FAIL handshake: no tx_ready within %0d cycles for byte %0h", n, d);
        end
        if (drop) begin tx_valid = 1'b0; tx_data = DW'($urandom); tx_dc = 1'($urandom); end
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin @(negedge clk); n++; end while ((busy || !tx_ready) && n < 3000);
        if (n >= 3000) begin total++; $display("FAIL wait_idle: busy=%0d after %0d cycles", busy, n); end
        @(posedge clk); #1;
    endtask

    task automatic expect_byte(input string name, input logic [DW-1:0] d, input logic c);
        logic [8:0] o;
        if (obs_q.size() == 0) begin
            total++;
            $display("FAIL %s: no byte on wire, expected %0h", name, d);
        end else begin
            o = obs_q.pop_front();
            check({name, " mosi"}, o[DW-1:0], d);
            check({name, " dc"}, o[8], c);
        end
    endtask

    typedef struct {
        logic [DW-1:0] data;
        logic          dc;
        int            exp_len;
        int            exp_rises;
        int            exp_done;
        int            exp_shifts;
    } vec_t;

    vec_t vecs[6];
    logic [8:0] sent_q[$];

    initial begin
        int l0, s0, d0, w0, n;
        logic [DW-1:0] rd;
        logic rc;
        int g;

        // Single-byte frames: SETUP(2) + 8 bits * 2 * CLK_DIV(2) + NEXT(1) = 35 cycles low
        vecs[0] = '{8'hA5, 1'b0, 35, 8, 1, 8};
        vecs[1] = '{8'h3C, 1'b1, 35, 8, 1, 8};
        vecs[2] = '{8'h00, 1'b1, 35, 8, 1, 8};
        vecs[3] = '{8'hFF, 1'b0, 35, 8, 1, 8};
        vecs[4] = '{8'h80, 1'b0, 35, 8, 1, 8};
        vecs[5] = '{8'h01, 1'b1, 35, 8, 1, 8};

        rst = 1'b1; tx_valid = 0; tx_data = '0; tx_dc = 0;
        b_valid = 0; b_data = '0; b_dc = 0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst cs_n", spi_cs_n, 1);
        check("rst sck", spi_sck, 0);
        check("rst tx_ready", tx_ready, 0);
        check("rst dc", spi_dc, 0);
        check("rst done", byte_done, 0);
        check("rst shift_en", sr_shift_en, 0);
        check("rst busy", busy, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("post-rst tx_ready", tx_ready, 1);

        // Reset in the middle of a byte (SCK high) aborts at once
        @(posedge clk); #1;
        send(8'hF0, 1'b1, 1);
        repeat (9) @(negedge clk);
        check("pre-abort cs_n", spi_cs_n, 0);
        check("pre-abort sck", spi_sck, 1);
        @(posedge clk); #1 rst = 1'b1;
        #1;
        check("abort cs_n", spi_cs_n, 1);
        check("abort sck", spi_sck, 0);
        check("abort tx_ready", tx_ready, 0);
        check("abort dc", spi_dc, 0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("abort release tx_ready", tx_ready, 1);
        check("abort no byte", obs_q.size(), 0);
        @(posedge clk); #1;

        // Table of isolated single bytes
        foreach (vecs[i]) begin
            l0 = loads; s0 = shifts; d0 = dones; w0 = win_count;
            send(vecs[i].data, vecs[i].dc, 1);
            wait_idle();
            expect_byte($sformatf("vec%0d", i), vecs[i].data, vecs[i].dc);
            check($sformatf("vec%0d cs_low", i), last_len, vecs[i].exp_len);
            check($sformatf("vec%0d sck", i), last_rises, vecs[i].exp_rises);
            check($sformatf("vec%0d done", i), dones - d0, vecs[i].exp_done);
            check($sformatf("vec%0d shifts", i), shifts - s0, vecs[i].exp_shifts);
            check($sformatf("vec%0d loads", i), loads - l0, 1);
            check($sformatf("vec%0d windows", i), win_count - w0, 1);
        end

        // Burst of three bytes with valid held high
        d0 = dones; w0 = win_count; l0 = loads; s0 = shifts;
        send(8'h2C, 1'b0, 0);
        send(8'h12, 1'b1, 0);
        send(8'h34, 1'b1, 1);
        wait_idle();
        check("burst windows", win_count - w0, 1);
        check("burst cs_low", last_len, CS_SETUP + 3 * BYTE_CYC);
        check("burst sck", last_rises, 24);
        check("burst done", dones - d0, 3);
        check("burst loads", loads - l0, 3);
        check("burst shifts", shifts - s0, 24);
        expect_byte("burst0", 8'h2C, 1'b0);
        expect_byte("burst1", 8'h12, 1'b1);
        expect_byte("burst2", 8'h34, 1'b1);

        // Valid returns during HOLD: not accepted until IDLE, fresh SETUP follows
        w0 = win_count;
        send(8'h96, 1'b0, 1);
        n = 0;
        while (!byte_done && n < 200) begin @(negedge clk); n++; end
        check("gap byte_done seen", byte_done, 1);
        @(posedge clk); #1;
        tx_valid = 1'b1; tx_data = 8'h69; tx_dc = 1'b1;
        for (int i = 0; i < int'(CS_IDLE); i++) begin
            @(negedge clk);
            check($sformatf("hold ready %0d", i), tx_ready, 0);
        end
        send(8'h69, 1'b1, 1);
        wait_idle();
        check("gap windows", win_count - w0, 2);
        check("gap cs_low", last_len, CS_SETUP + BYTE_CYC);
        check("gap cs_high", gap_at_start, CS_IDLE + 1);
        expect_byte("gap0", 8'h96, 1'b0);
        expect_byte("gap1", 8'h69, 1'b1);

        // Fast instance: SCK toggles every clk
        b_valid = 1'b1; b_data = 8'hC3; b_dc = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!b_ready && n < 50);
        @(posedge clk); #1 b_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!b_byte_done && n < 100);
        @(negedge clk);
        check("fast done latency", b_lat - (CS_SETUP + 1), 16);
        check("fast sck rises", b_rises, 8);
        check("fast sck high cycles", b_hi, 8);

        // Random traffic against the queue model
        @(posedge clk); #1;
        sent_q.delete();
        for (int i = 0; i < 40; i++) begin
            rd = DW'($urandom);
            rc = 1'($urandom);
            g  = $urandom_range(0, 4);
            send(rd, rc, g != 0);
            sent_q.push_back({rc, rd});
            repeat (g) begin @(posedge clk); #1; end
        end
        tx_valid = 1'b0;
        wait_idle();
        check("rand byte count", obs_q.size(), sent_q.size());
        foreach (sent_q[i]) begin
            expect_byte($sformatf("rand%0d", i), sent_q[i][DW-1:0], sent_q[i][8]);
        end

        check("strobe coincidence", v_coinc, 0);
        check("busy window", v_busy, 0);
        check("sck high width", v_high, 0);
        check("frame shape", v_win, 0);
        check("cs idle gap", v_gap, 0);
        check("leftover bytes", obs_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
